// File: rtl/prog_loader.sv
`default_nettype none
// ============================================================================
// Module   : prog_loader
// Purpose  : Loads a 16-word program plus checksum over a valid/ready byte
//            stream into a 16x8 register array. The array serves the core's
//            instruction fetch combinationally. The core is held in reset
//            until a program has loaded with a matching checksum.
// Revision : 1.0 - initial release
// ============================================================================
module prog_loader #(
  parameter int DEPTH = 16,
  parameter int AW    = 4,
  parameter int IW    = 8
) (
  input  logic          clk,
  input  logic          resetn,
  input  logic          start,
  input  logic          in_valid,
  input  logic [IW-1:0] in_data,
  output logic          in_ready,
  input  logic [AW-1:0] addr,
  output logic [IW-1:0] inst,
  output logic          core_resetn,
  output logic          busy,
  output logic          done,
  output logic          err
);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_LOAD  = 3'd1;
  localparam logic [2:0] S_CHECK = 3'd2;
  localparam logic [2:0] S_RUN   = 3'd3;
  localparam logic [2:0] S_ERR   = 3'd4;

  localparam logic [AW-1:0] LAST_WORD = AW'(DEPTH - 1);

  logic [2:0]    state_q, state_d;
  logic [AW-1:0] cnt_q, cnt_d;
  logic [IW-1:0] sum_q, sum_d;
  logic          core_resetn_q;
  logic [IW-1:0] mem_q [DEPTH];
  logic          xfer;
  logic          wr_en;

  // in_ready depends only on registered state, never on in_valid
  assign in_ready = (state_q == S_LOAD) || (state_q == S_CHECK);
  assign xfer     = in_valid & in_ready;
  assign wr_en    = xfer && (state_q == S_LOAD);

  assign busy        = (state_q == S_LOAD) || (state_q == S_CHECK);
  assign done        = (state_q == S_RUN);
  assign err         = (state_q == S_ERR);
  assign core_resetn = core_resetn_q;
  assign inst        = mem_q[addr];

  // Next-state, word counter and running checksum
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    sum_d   = sum_q;
    case (state_q)
      S_IDLE, S_RUN, S_ERR: begin
        if (start) begin
          state_d = S_LOAD;
          cnt_d   = '0;
          sum_d   = '0;
        end
      end
      S_LOAD: begin
        if (xfer) begin
          sum_d = sum_q + in_data;
          cnt_d = cnt_q + 1'b1;
          if (cnt_q == LAST_WORD) begin
            state_d = S_CHECK;
          end
        end
      end
      S_CHECK: begin
        if (xfer) begin
          state_d = (in_data == sum_q) ? S_RUN : S_ERR;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Control registers; core reset released only on entry to RUN
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q       <= S_IDLE;
      cnt_q         <= '0;
      sum_q         <= '0;
      core_resetn_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      sum_q         <= sum_d;
      core_resetn_q <= (state_d == S_RUN);
    end
  end

  // Instruction store: cleared on reset, overwritten in place on reload
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else if (wr_en) begin
      mem_q[cnt_q] <= in_data;
    end
  end

endmodule
`default_nettype wire
